// File: rtl/mem_arbiter.sv
// Two-requester (fetch I / load-store D) round-robin arbiter and sequencer for one shared memory port.
// Define MEM_TIMEOUT_EN to add a bus timeout that aborts a stalled transfer after TIMEOUT_CYCLES busy cycles.
module mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_valid,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_ready,
  input  logic        d_valid,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic        mem_valid,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        fault
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("mem_arbiter: TIMEOUT_CYCLES must be in 1..65535");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  state_t      state, state_nx;
  logic        last_grant_d, last_grant_d_nx;  // 1: D held the most recent grant
  logic [31:0] addr_q, addr_nx;
  logic [31:0] wdata_q, wdata_nx;
  logic [3:0]  wstrb_q, wstrb_nx;
  logic        busy;
  logic        abort;
  logic        done;

  assign busy = (state != IDLE);

`ifdef MEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] tmo_cnt;

  // Held at zero while idle, so every BUSY entry starts counting from zero.
  always_ff @(posedge clk) begin
    if (rst || !busy) begin
      tmo_cnt <= '0;
    end else if (!mem_ready) begin
      tmo_cnt <= tmo_cnt + CW'(1);
    end
  end

  assign abort = busy && !rst && !mem_ready && (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  assign abort = 1'b0;
`endif

  // A transfer being reset away never reports completion.
  assign done  = busy && !rst && (mem_ready || abort);
  assign fault = abort;

  assign i_ready = (state == BUSY_I) && done;
  assign d_ready = (state == BUSY_D) && done;
  assign i_rdata = ((state == BUSY_I) && !rst && mem_ready) ? mem_rdata : '0;
  assign d_rdata = ((state == BUSY_D) && !rst && mem_ready) ? mem_rdata : '0;

  assign mem_valid = busy;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wstrb = wstrb_q;

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      last_grant_d <= 1'b1;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
    end else begin
      state        <= state_nx;
      last_grant_d <= last_grant_d_nx;
      addr_q       <= addr_nx;
      wdata_q      <= wdata_nx;
      wstrb_q      <= wstrb_nx;
    end
  end

  // NOTE: every signal driven here gets its default first, so no path can infer a latch.
  always_comb begin
    state_nx        = state;
    last_grant_d_nx = last_grant_d;
    addr_nx         = addr_q;
    wdata_nx        = wdata_q;
    wstrb_nx        = wstrb_q;

    unique case (state)
      IDLE: begin
        if (i_valid && (!d_valid || last_grant_d)) begin
          state_nx        = BUSY_I;
          last_grant_d_nx = 1'b0;
          addr_nx         = i_addr;
          wdata_nx        = '0;
          wstrb_nx        = '0;
        end else if (d_valid) begin
          state_nx        = BUSY_D;
          last_grant_d_nx = 1'b1;
          addr_nx         = d_addr;
          wdata_nx        = d_wdata;
          wstrb_nx        = d_wstrb;
        end
      end
      BUSY_I, BUSY_D: begin
        if (done) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter and sequencer for the core's single shared memory port.
- Requester I is instruction fetch (read-only). Requester D is execute-stage load/store, using the same valid/addr/wdata/wstrb/rdata bus the execute stage drives.
- Latches one request at a time and drives it onto the memory port until the memory acknowledges with mem_ready.
- Returns read data and a one-cycle ready pulse to the granted requester, with round-robin fairness between I and D.

Parameters:
- TIMEOUT_CYCLES, 255: busy cycles without mem_ready before a forced abort. Used only when MEM_TIMEOUT_EN is defined; valid range 1..65535.

Ports:
- clk  input  1  clock; all state changes on the rising edge
- rst  input  1  synchronous, active-high reset
- i_valid  input  1  fetch request pending
- i_addr  input  32  fetch byte address
- i_rdata  output  32  fetch read data; valid when i_ready=1
- i_ready  output  1  one-cycle pulse: fetch transfer complete
- d_valid  input  1  load/store request pending
- d_addr  input  32  load/store byte address
- d_wdata  input  32  store data
- d_wstrb  input  4  byte strobes; 0000 = load
- d_rdata  output  32  load read data; valid when d_ready=1
- d_ready  output  1  one-cycle pulse: load/store transfer complete
- mem_valid  output  1  memory request active
- mem_addr  output  32  memory address
- mem_wdata  output  32  memory write data
- mem_wstrb  output  4  memory write strobes
- mem_rdata  input  32  memory read data
- mem_ready  input  1  memory acknowledge
- fault  output  1  one-cycle pulse on bus timeout; constant 0 without MEM_TIMEOUT_EN

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous, active-high.
- Reset values: state=IDLE, mem_valid=0, mem_addr/mem_wdata=0, mem_wstrb=0, i_ready=d_ready=0, fault=0, last_grant=D (so I wins the first tie), timeout counter=0.
- FSM states: IDLE, BUSY_I, BUSY_D.
- IDLE, arbitration on sampled valids:
  - Only i_valid: go to BUSY_I.
  - Only d_valid: go to BUSY_D.
  - Both: grant the requester other than last_grant.
  - Neither: stay in IDLE.
  - On grant: latch addr; for D also latch wdata and wstrb; update last_grant.
- BUSY_x:
  - mem_valid=1; mem_addr/wdata/wstrb come from the latched registers and are stable for the whole state.
  - BUSY_I always drives mem_wstrb=0000 and mem_wdata=0.
- Completion:
  - In BUSY_x with mem_ready=1: x_ready=1 combinationally in that cycle, x_rdata=mem_rdata passthrough; next state is IDLE.
  - Ungranted requester's ready stays 0. x_rdata is 0 whenever x_ready=0.
- Latency: request sampled in cycle 0 → mem_valid in cycle 1 → earliest x_ready in cycle 1 → IDLE in cycle 2. Back-to-back transactions have a one-cycle IDLE bubble, giving a peak of one transfer per 2 cycles.
- Handshake rules:
  - A requester holds valid and its fields stable until its ready pulse.
  - A transfer completes on the edge where x_ready=1.
  - In the following cycle, x_valid reflects that requester's next request.
  - Arbitration only happens in IDLE; a valid asserted during BUSY waits.
- Request fields changing during BUSY are ignored; the latched values are used.
- mem_ready while in IDLE is ignored.
- Reset mid-transaction: on the next edge the state is IDLE and mem_valid=0. No ready pulse is issued for the aborted transaction, and last_grant returns to D.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to BUSY and increments each BUSY cycle with mem_ready=0.
  - When the count reaches TIMEOUT_CYCLES-1 and mem_ready is still 0: x_ready=1, x_rdata=0 and fault=1 for that cycle; next state is IDLE.
  - The counter is sized clog2(TIMEOUT_CYCLES+1) bits.
- Undefined: no counter is present, BUSY waits indefinitely for mem_ready, and fault is tied to 0.

Test Plan:
- Single fetch: i_valid=1, i_addr=0x100, mem_ready=1 with mem_rdata=0x00000013 → cycle 1: mem_valid=1, mem_addr=0x100, mem_wstrb=0000, i_ready=1, i_rdata=0x13; cycle 2: mem_valid=0.
- Tie-break alternation: both valid continuously after reset, mem_ready=1 → grant order I,D,I,D; i_ready/d_ready alternate every 2 cycles, never both in one cycle.
- Stalled store: d_addr=0x2000, d_wdata=0xDEADBEEF, d_wstrb=1111, mem_ready low for 3 busy cycles then high → mem_* held constant for 4 cycles; single d_ready pulse in the 4th; i_ready=0 throughout even with i_valid=1.
- Field change during BUSY: d_addr changes from 0x2000 to 0x3000 while BUSY_D → mem_addr stays 0x2000 until completion.
- Reset mid-op: rst asserted in the 2nd BUSY_D cycle → next cycle mem_valid=0, d_ready never pulses; afterwards both valid → I granted first.
- Timeout (MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4): D load with mem_ready=0 forever → in the 4th busy cycle d_ready=1, d_rdata=0, fault=1; next cycle IDLE and fault=0. Without the macro, mem_valid stays 1 for 20+ cycles and fault=0.
